// File: rtl/regbank_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : regbank_operand_fetch
// Description : Read side of the register bank. Accepts operand-fetch requests
//               (two source indices), snapshots the selected registers at the
//               accept edge and presents the operand pair to the ALU through a
//               2-entry in-order valid/ready buffer.
//
//               Optional feature macro: REGFETCH_BYPASS_EN
//                 defined   - at accept, a source whose bank write enable is
//                             set in the same cycle captures ALUBus (the value
//                             being written) instead of the stale bank value.
//                 undefined - operands always come from regFlat; ALUBus and
//                             regEnable are ignored.
//
// Ports       : clk        in   system clock, rising edge
//               reset      in   asynchronous active-high, clears buffer state
//               regFlat    in   bank contents, r_i = regFlat[WIDTH*i +: WIDTH]
//               ALUBus     in   write data currently presented to the bank
//               regEnable  in   bank write enables, bit i selects r_i
//               req_valid  in   decode presents a fetch request
//               req_srcA   in   index of operand A
//               req_srcB   in   index of operand B
//               req_ready  out  buffer can accept a request this cycle
//               op_valid   out  head entry holds a valid operand pair
//               op_ready   in   ALU consumes the head entry this cycle
//               opA / opB  out  operands of the head entry
//               op_srcA/B  out  indices that produced opA / opB
//
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_operand_fetch #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 16,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH*NREGS-1:0]   regFlat,
    input  logic [WIDTH-1:0]         ALUBus,
    input  logic [NREGS-1:0]         regEnable,
    input  logic                     req_valid,
    input  logic [IDX_W-1:0]         req_srcA,
    input  logic [IDX_W-1:0]         req_srcB,
    output logic                     req_ready,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [WIDTH-1:0]         opA,
    output logic [WIDTH-1:0]         opB,
    output logic [IDX_W-1:0]         op_srcA,
    output logic [IDX_W-1:0]         op_srcB
);

    // Buffer occupancy encoding
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // Head entry drives the outputs; tail entry only exists while FULL
    logic [WIDTH-1:0]  r_head_a;
    logic [WIDTH-1:0]  r_head_b;
    logic [IDX_W-1:0]  r_head_sa;
    logic [IDX_W-1:0]  r_head_sb;
    logic [WIDTH-1:0]  r_tail_a;
    logic [WIDTH-1:0]  r_tail_b;
    logic [IDX_W-1:0]  r_tail_sa;
    logic [IDX_W-1:0]  r_tail_sb;

    logic              w_accept;
    logic              w_pop;
    logic              w_load_head_new;
    logic              w_load_head_tail;
    logic              w_load_tail;

    logic [WIDTH-1:0]  w_regs [NREGS];
    logic [WIDTH-1:0]  w_fetch_a;
    logic [WIDTH-1:0]  w_fetch_b;

    // Unpack the flat bank bus so registers can be selected by index
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_unpack
        assign w_regs[gi] = regFlat[gi*WIDTH +: WIDTH];
    end

`ifdef REGFETCH_BYPASS_EN
    // A register being written this cycle is forwarded from the write bus so
    // the fetched operand matches what the bank will hold after the edge.
    assign w_fetch_a = regEnable[req_srcA] ? ALUBus : w_regs[req_srcA];
    assign w_fetch_b = regEnable[req_srcB] ? ALUBus : w_regs[req_srcB];
`else
    assign w_fetch_a = w_regs[req_srcA];
    assign w_fetch_b = w_regs[req_srcB];
    // Write-port snoop is kept on the interface but has no function here
    logic w_unused_snoop;
    assign w_unused_snoop = ^{ALUBus, regEnable};
`endif

    // Handshakes: ready depends only on occupancy, never on op_ready
    assign req_ready = (r_state != c_ST_FULL);
    assign op_valid  = (r_state != c_ST_EMPTY);
    assign w_accept  = req_valid & req_ready;
    assign w_pop     = op_valid & op_ready;

    assign opA     = r_head_a;
    assign opB     = r_head_b;
    assign op_srcA = r_head_sa;
    assign op_srcB = r_head_sb;

    // Next-state and entry-load selection
    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_new  = 1'b0;
        w_load_head_tail = 1'b0;
        w_load_tail      = 1'b0;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt     = c_ST_ONE;
                    w_load_head_new = 1'b1;
                end
            end
            c_ST_ONE: begin
                if (w_accept && !w_pop) begin
                    w_state_nxt = c_ST_FULL;
                    w_load_tail = 1'b1;
                end else if (!w_accept && w_pop) begin
                    w_state_nxt = c_ST_EMPTY;
                end else if (w_accept && w_pop) begin
                    // Old head leaves as the new request takes its place
                    w_load_head_new = 1'b1;
                end
            end
            c_ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt      = c_ST_ONE;
                    w_load_head_tail = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_a  <= '0;
            r_head_b  <= '0;
            r_head_sa <= '0;
            r_head_sb <= '0;
        end else if (w_load_head_new) begin
            r_head_a  <= w_fetch_a;
            r_head_b  <= w_fetch_b;
            r_head_sa <= req_srcA;
            r_head_sb <= req_srcB;
        end else if (w_load_head_tail) begin
            r_head_a  <= r_tail_a;
            r_head_b  <= r_tail_b;
            r_head_sa <= r_tail_sa;
            r_head_sb <= r_tail_sb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tail_a  <= '0;
            r_tail_b  <= '0;
            r_tail_sa <= '0;
            r_tail_sb <= '0;
        end else if (w_load_tail) begin
            r_tail_a  <= w_fetch_a;
            r_tail_b  <= w_fetch_b;
            r_tail_sa <= req_srcA;
            r_tail_sb <= req_srcB;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regbank_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_operand_fetch
// Description : Directed bench for regbank_operand_fetch. A behavioural bank
//               and a queue of expected operand pairs track every accepted
//               request; outputs are compared at each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_operand_fetch;

    logic          clk = 1'b0;
    logic          reset;
    logic [255:0]  regFlat;
    logic [15:0]   ALUBus;
    logic [15:0]   regEnable;
    logic          req_valid;
    logic [3:0]    req_srcA;
    logic [3:0]    req_srcB;
    logic          req_ready;
    logic          op_valid;
    logic          op_ready;
    logic [15:0]   opA;
    logic [15:0]   opB;
    logic [3:0]    op_srcA;
    logic [3:0]    op_srcB;

    logic [15:0]   bank [16];

    typedef struct packed {
        logic [3:0]  sa;
        logic [3:0]  sb;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t q [$];
    int   tests = 0;
    int   fails = 0;
    bit   last_acc;

    always #5 clk = ~clk;

    always_comb begin
        regFlat = '0;
        for (int i = 0; i < 16; i++) regFlat[i*16 +: 16] = bank[i];
    end

    regbank_operand_fetch #(.WIDTH(16), .NREGS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .regFlat   (regFlat),
        .ALUBus    (ALUBus),
        .regEnable (regEnable),
        .req_valid (req_valid),
        .req_srcA  (req_srcA),
        .req_srcB  (req_srcB),
        .req_ready (req_ready),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opA       (opA),
        .opB       (opB),
        .op_srcA   (op_srcA),
        .op_srcB   (op_srcB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value the fetch should capture for an index at the accept edge
    function automatic logic [15:0] model_fetch(input logic [3:0] idx);
`ifdef REGFETCH_BYPASS_EN
        if (regEnable[idx]) return ALUBus;
`endif
        return bank[idx];
    endfunction

    // One clock: check outputs at the falling edge, update the scoreboard at
    // the rising edge, apply bank writes shortly after it.
    task automatic cycle();
        exp_t h;
        exp_t e;
        bit   do_pop;
        bit   do_acc;
        @(negedge clk);
        check("op_valid", {31'd0, op_valid}, {31'd0, q.size() != 0});
        check("req_ready", {31'd0, req_ready}, {31'd0, q.size() < 2});
        if (q.size() != 0) begin
            h = q[0];
            check("opA", {16'd0, opA}, {16'd0, h.a});
            check("opB", {16'd0, opB}, {16'd0, h.b});
            check("op_srcA", {28'd0, op_srcA}, {28'd0, h.sa});
            check("op_srcB", {28'd0, op_srcB}, {28'd0, h.sb});
        end
        do_pop = (q.size() != 0) && op_ready;
        do_acc = req_valid && (q.size() < 2);
        e.sa = req_srcA;
        e.sb = req_srcB;
        e.a  = model_fetch(req_srcA);
        e.b  = model_fetch(req_srcB);
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_acc) q.push_back(e);
        last_acc = do_acc;
        for (int i = 0; i < 16; i++) if (regEnable[i]) bank[i] = ALUBus;
    endtask

    task automatic set_req(input logic v, input logic [3:0] a, input logic [3:0] b);
        req_valid = v;
        req_srcA  = a;
        req_srcB  = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_valid"}, {31'd0, op_valid}, 32'd0);
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_opA"}, {16'd0, opA}, 32'd0);
        check({tag, "_opB"}, {16'd0, opB}, 32'd0);
        check({tag, "_op_srcA"}, {28'd0, op_srcA}, 32'd0);
        check({tag, "_op_srcB"}, {28'd0, op_srcB}, 32'd0);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        ALUBus    = '0;
        regEnable = '0;
        op_ready  = 1'b0;
        set_req(1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++) bank[i] = 16'h1000 + 16'(i);
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Read r3/r9, single beat consumed immediately
        bank[3]  = 16'hAAAA;
        bank[9]  = 16'h0089;
        op_ready = 1'b1;
        set_req(1'b1, 4'd3, 4'd9);
        cycle();
        set_req(1'b0, 4'd0, 4'd0);
        cycle();
        cycle();

        // Back-pressure: two accepted, third stalls until buffer leaves FULL
        op_ready = 1'b0;
        set_req(1'b1, 4'd1, 4'd2);
        cycle();
        set_req(1'b1, 4'd4, 4'd5);
        cycle();
        set_req(1'b1, 4'd6, 4'd7);
        cycle();
        check("third_stalled", {31'd0, last_acc}, 32'd0);
        cycle();
        op_ready = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        check("third_accepted", {31'd0, last_acc}, 32'd1);
        set_req(1'b0, 4'd0, 4'd0);
        repeat (3) cycle();

        // Streaming accept+pop over an identity-style bank
        for (int i = 0; i < 16; i++) bank[i] = 16'h8000 >> i;
        op_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_req(1'b1, 4'(i), 4'(15 - i));
            cycle();
        end
        set_req(1'b0, 4'd0, 4'd0);
        repeat (2) cycle();

        // Same-cycle write to r5 while fetching (5,5)
        bank[5]   = 16'h0000;
        ALUBus    = 16'h1234;
        regEnable = 16'h0020;
        set_req(1'b1, 4'd5, 4'd5);
        cycle();
        regEnable = '0;
        set_req(1'b0, 4'd0, 4'd0);
        cycle();

        // Multiple write enables: r0 and r8 both written with ALUBus
        bank[0]   = 16'h0F0F;
        bank[8]   = 16'h00F0;
        ALUBus    = 16'hBEEF;
        regEnable = 16'h0101;
        set_req(1'b1, 4'd0, 4'd8);
        cycle();
        regEnable = '0;
        set_req(1'b0, 4'd0, 4'd0);
        repeat (2) cycle();

        // Snapshot: entry holds while r2 is overwritten behind it
        bank[2]  = 16'h0001;
        op_ready = 1'b0;
        set_req(1'b1, 4'd2, 4'd2);
        cycle();
        set_req(1'b0, 4'd0, 4'd0);
        ALUBus    = 16'hFFFF;
        regEnable = 16'h0004;
        cycle();
        regEnable = '0;
        repeat (3) cycle();
        op_ready = 1'b1;
        repeat (2) cycle();

        // Asynchronous reset with a full buffer
        op_ready = 1'b0;
        set_req(1'b1, 4'd10, 4'd11);
        cycle();
        set_req(1'b1, 4'd12, 4'd13);
        cycle();
        set_req(1'b0, 4'd0, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Accept on the first edge after release, then drain
        op_ready = 1'b1;
        set_req(1'b1, 4'd14, 4'd0);
        cycle();
        set_req(1'b0, 4'd0, 4'd0);
        repeat (2) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
